// File: rtl/encode_64b67b_lanes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : encode_64b67b_lanes
// Purpose  : Multi-lane 64B/67B running-disparity encoder with a two-stage
//            stallable valid/ready pipeline, per-lane passthrough, sticky
//            disparity alarms and a saturating inversion counter.
// Revision : 1.0  initial release
// ============================================================================
module encode_64b67b_lanes #(
   parameter int LANES      = 4,
   parameter int DISP_WIDTH = 16,
   parameter int DISP_LIMIT = 96,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                    USER_CLK,
   input  logic                    SYSTEM_RESET_N,
   input  logic [64*LANES-1:0]     DATA_IN,
   input  logic [2*LANES-1:0]      HEADER_IN,
   input  logic                    DATA_IN_VALID,
   output logic                    DATA_IN_READY,
   output logic [67*LANES-1:0]     DATA_OUT,
   output logic                    DATA_OUT_VALID,
   input  logic                    DATA_OUT_READY,
   input  logic [LANES-1:0]        PASSTHROUGH,
   output logic [LANES-1:0]        DISP_ALARM,
   output logic [CNT_WIDTH-1:0]    INV_COUNT,
   input  logic                    STAT_CLEAR
);

   localparam int                     c_nw      = $clog2(LANES + 1);
   localparam logic signed [DISP_WIDTH-1:0] c_wd_bias = DISP_WIDTH'(64);
   localparam logic signed [DISP_WIDTH-1:0] c_one     = DISP_WIDTH'(1);
   localparam logic signed [DISP_WIDTH-1:0] c_limit   = DISP_WIDTH'(DISP_LIMIT);

   // stage 1: captured word plus per-lane ones count
   logic                        s1_valid_q, s1_valid_d;
   logic [64*LANES-1:0]         s1_data_q,  s1_data_d;
   logic [2*LANES-1:0]          s1_hdr_q,   s1_hdr_d;
   logic [LANES-1:0]            s1_pt_q,    s1_pt_d;
   logic [7*LANES-1:0]          s1_ones_q,  s1_ones_d;

   // stage 2: output register and running state
   logic                        out_valid_q, out_valid_d;
   logic [67*LANES-1:0]         out_data_q,  out_data_d;
   logic [DISP_WIDTH*LANES-1:0] rd_q,        rd_d;
   logic [LANES-1:0]            alarm_q,     alarm_d;
   logic [CNT_WIDTH-1:0]        cnt_q,       cnt_d;

   logic                        w_adv1, w_adv2;
   logic [6:0]                  w_pop;
   logic signed [DISP_WIDTH-1:0] w_wd, w_rd, w_rdn, w_abs;
   logic [c_nw-1:0]             w_ninv;
   logic [CNT_WIDTH:0]          w_sum;

   // a stage advances when its successor is empty or itself advancing
   assign w_adv2 = ~out_valid_q | DATA_OUT_READY;
   assign w_adv1 = ~s1_valid_q | w_adv2;

   assign DATA_IN_READY  = SYSTEM_RESET_N & w_adv1;
   assign DATA_OUT       = out_data_q;
   assign DATA_OUT_VALID = out_valid_q;
   assign DISP_ALARM     = alarm_q;
   assign INV_COUNT      = cnt_q;

   // stage 1 next state: capture the word and count ones per lane
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_hdr_d   = s1_hdr_q;
      s1_pt_d    = s1_pt_q;
      s1_ones_d  = s1_ones_q;
      w_pop      = '0;
      if (w_adv1) begin
         s1_valid_d = DATA_IN_VALID;
         if (DATA_IN_VALID) begin
            s1_data_d = DATA_IN;
            s1_hdr_d  = HEADER_IN;
            s1_pt_d   = PASSTHROUGH;
            for (int k = 0; k < LANES; k++) begin
               w_pop = '0;
               for (int i = 0; i < 64; i++) begin
                  if (DATA_IN[64*k+i]) w_pop = w_pop + 7'd1;
               end
               s1_ones_d[7*k +: 7] = w_pop;
            end
         end
      end
   end

   // stage 2 next state: inversion decision, disparity update, statistics
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rd_d        = rd_q;
      alarm_d     = alarm_q;
      cnt_d       = cnt_q;
      w_wd        = '0;
      w_rd        = '0;
      w_rdn       = '0;
      w_abs       = '0;
      w_ninv      = '0;
      w_sum       = '0;
      if (w_adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            for (int k = 0; k < LANES; k++) begin
               // word disparity = 2*ones - 64
               w_wd = $signed({{(DISP_WIDTH-8){1'b0}}, s1_ones_q[7*k +: 7], 1'b0}) - c_wd_bias;
               w_rd = rd_q[DISP_WIDTH*k +: DISP_WIDTH];
               if (s1_pt_q[k]) begin
                  out_data_d[67*k +: 67] = {1'b0, s1_hdr_q[2*k +: 2], s1_data_q[64*k +: 64]};
                  w_rdn = '0;
               end else if (w_rd[DISP_WIDTH-1] == w_wd[DISP_WIDTH-1]) begin
                  // same sign (zero counts as non-negative): invert to pull RD back
                  out_data_d[67*k +: 67] = {1'b1, s1_hdr_q[2*k +: 2], ~s1_data_q[64*k +: 64]};
                  w_rdn  = w_rd - w_wd + c_one;
                  w_ninv = w_ninv + c_nw'(1);
               end else begin
                  out_data_d[67*k +: 67] = {1'b0, s1_hdr_q[2*k +: 2], s1_data_q[64*k +: 64]};
                  w_rdn = w_rd + w_wd - c_one;
               end
               rd_d[DISP_WIDTH*k +: DISP_WIDTH] = w_rdn;
               w_abs = w_rdn[DISP_WIDTH-1] ? -w_rdn : w_rdn;
               if (w_abs > c_limit) alarm_d[k] = 1'b1;
            end
            w_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(w_ninv);
            cnt_d = w_sum[CNT_WIDTH] ? '1 : w_sum[CNT_WIDTH-1:0];
         end
      end
      // clear takes priority over any same-cycle increment or alarm
      if (STAT_CLEAR) begin
         alarm_d = '0;
         cnt_d   = '0;
      end
   end

   // pipeline and statistics registers, async active-low reset
   always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
      if (!SYSTEM_RESET_N) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_hdr_q    <= '0;
         s1_pt_q     <= '0;
         s1_ones_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rd_q        <= '0;
         alarm_q     <= '0;
         cnt_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_hdr_q    <= s1_hdr_d;
         s1_pt_q     <= s1_pt_d;
         s1_ones_q   <= s1_ones_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rd_q        <= rd_d;
         alarm_q     <= alarm_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
`default_nettype wire
